// File: rtl/rtmq_cfg_loader_pkg.sv
// rtmq_cfg_loader_pkg: shared constants and types for the
// RTMQ configuration-override loader.
package rtmq_cfg_loader_pkg;

  localparam int RTMQ_W_REG = 32;
  localparam int N_CFG_GAP  = 2;
  localparam int T_CFG_TMO  = 1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_GAP
  } inj_state_t;

endpackage

// File: rtl/rtmq_sync_fifo.sv
// rtmq_sync_fifo: single-clock FIFO, head word visible on dout,
// occupancy on cnt, synchronous active-high reset.
module rtmq_sync_fifo
  import rtmq_cfg_loader_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != (AW+1)'(DEPTH)) | do_pop);
  assign dout    = mem[rp];

  // storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rtmq_cfg_loader.sv
// rtmq_cfg_loader: assembles host bytes into instructions and
// injects them into the core as spaced f_cfg pulses.
module rtmq_cfg_loader
  import rtmq_cfg_loader_pkg::*;
#(
  parameter int W_REG      = RTMQ_W_REG,
  parameter int FIFO_DEPTH = 4,
  parameter int N_GAP      = N_CFG_GAP,
  parameter int T_TMO      = T_CFG_TMO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_dat,
  input  logic             rx_vld,
  output logic             rx_rdy,
  input  logic             cfg_en,
  output logic             f_cfg,
  output logic [W_REG-1:0] cfg_ins,
  output logic             err_tmo,
  output logic             busy
);

  localparam int NB = W_REG / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(T_TMO + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (N_GAP > 0) ? $clog2(N_GAP + 1) : 1;

  logic [W_REG-1:0] asm_q;
  logic [BW-1:0]    bcnt;
  logic [TW-1:0]    tmo_cnt;
  logic             err_q;
  logic [W_REG+7:0] cat;
  logic [W_REG-1:0] word;
  logic             accept;
  logic             last;
  logic             push;
  logic             tmo_hit;

  logic [CW-1:0]    fifo_cnt;
  logic [W_REG-1:0] fifo_dout;

  inj_state_t       state_q;
  inj_state_t       state_d;
  logic [GW-1:0]    gap_q;
  logic [GW-1:0]    gap_d;
  logic             pop;
  logic             avail;
  logic             f_cfg_q;
  logic [W_REG-1:0] ins_q;

  assign cat     = {asm_q, rx_dat};
  assign word    = cat[W_REG-1:0];
  assign rx_rdy  = ~rst & (fifo_cnt < CW'(FIFO_DEPTH));
  assign accept  = rx_vld & rx_rdy;
  assign last    = (bcnt == BW'(NB - 1));
  assign push    = accept & last;
  assign tmo_hit = (bcnt != '0) & (tmo_cnt == TW'(T_TMO - 1));
  assign avail   = cfg_en & (fifo_cnt != '0);

  rtmq_sync_fifo #(
    .W     (W_REG),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (word),
    .dout (fifo_dout),
    .cnt  (fifo_cnt)
  );

  // byte assembly and partial-word timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q   <= '0;
      bcnt    <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        asm_q   <= word;
        bcnt    <= last ? '0 : bcnt + BW'(1);
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        bcnt    <= '0;
        tmo_cnt <= '0;
        err_q   <= 1'b1;
      end else if (bcnt != '0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // injection next-state and pop decision
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (avail) begin
          state_d = S_FIRE;
          pop     = 1'b1;
        end
      end
      S_FIRE: begin
        if (N_GAP == 0) begin
          state_d = avail ? S_FIRE : S_IDLE;
          pop     = avail;
        end else begin
          state_d = S_GAP;
          gap_d   = GW'(N_GAP);
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d = avail ? S_FIRE : S_IDLE;
          pop     = avail;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // injection state and registered strobe/instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      f_cfg_q <= 1'b0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      f_cfg_q <= pop;
      ins_q   <= pop ? fifo_dout : '0;
    end
  end

  assign f_cfg   = f_cfg_q;
  assign cfg_ins = ins_q;
  assign err_tmo = err_q;
  assign busy    = (bcnt != '0) | (fifo_cnt != '0) | f_cfg_q;

endmodule

// File: tb/tb_rtmq_cfg_loader.sv
// tb_rtmq_cfg_loader: directed tables, corner sequences and
// randomized traffic against a word-queue reference model.
module tb_rtmq_cfg_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_dat = '0;
  logic        rx_vld = 1'b0;
  logic        rx_vld0 = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_en0 = 1'b0;
  logic        rx_rdy, rx_rdy0;
  logic        f_cfg, f_cfg0;
  logic [31:0] cfg_ins, cfg_ins0;
  logic        err_tmo, err_tmo0;
  logic        busy, busy0;

  always #5 clk = ~clk;

  rtmq_cfg_loader #(
    .W_REG(32), .FIFO_DEPTH(4), .N_GAP(2), .T_TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_vld(rx_vld),
    .rx_rdy(rx_rdy), .cfg_en(cfg_en), .f_cfg(f_cfg),
    .cfg_ins(cfg_ins), .err_tmo(err_tmo), .busy(busy)
  );

  rtmq_cfg_loader #(
    .W_REG(32), .FIFO_DEPTH(4), .N_GAP(0), .T_TMO(TMO)
  ) dut0 (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_vld(rx_vld0),
    .rx_rdy(rx_rdy0), .cfg_en(cfg_en0), .f_cfg(f_cfg0),
    .cfg_ins(cfg_ins0), .err_tmo(err_tmo0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: bytes form words MSB-first, words queue in order
  logic [31:0] exp_q[$];
  logic [31:0] part = '0;
  int          nb = 0;
  int          idle = 0;
  int          cyc = 0;
  int          last_p = -1000;
  bit          en_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      nb = 0;
      idle = 0;
      last_p = -1000;
      en_prev = 1'b0;
    end else begin
      if (f_cfg) begin
        if (exp_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
        else chk("pulse_word", cfg_ins, exp_q.pop_front());
        chk("pulse_spacing", 32'(cyc - last_p >= 3), 32'd1);
        chk("pulse_enable", 32'(en_prev), 32'd1);
        last_p = cyc;
      end else begin
        chk("cfg_ins_idle", cfg_ins, 32'd0);
      end
      if (rx_vld && rx_rdy) begin
        part = {part[23:0], rx_dat};
        nb++;
        idle = 0;
        if (nb == 4) begin
          exp_q.push_back(part);
          nb = 0;
        end
      end else if (nb != 0) begin
        idle++;
        if (idle == TMO) begin
          nb = 0;
          idle = 0;
        end
      end
      en_prev = cfg_en;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // expects to be called just after a rising edge
  task automatic send_byte(input logic [7:0] b, input bit sel);
    int n;
    n = 0;
    rx_dat = b;
    if (sel) rx_vld0 = 1'b1;
    else rx_vld = 1'b1;
    while (1) begin
      @(negedge clk);
      if (sel ? rx_rdy0 : rx_rdy) break;
      n++;
      if (n > 200) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_vld = 1'b0;
    rx_vld0 = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit sel);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], sel);
  endtask

  task automatic wait_pulse(output int n, input int maxc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!f_cfg && n < maxc);
    if (!f_cfg) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, pc, acc, errs;
    int pulses[$];
    logic [31:0] words0[$];

    tbl[0] = '{32'h12345678, 32'h12345678};
    tbl[1] = '{32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{32'h00000000, 32'h00000000};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{32'h80000001, 32'h80000001};
    tbl[5] = '{32'hA5A55A5A, 32'hA5A55A5A};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("rst_f_cfg", 32'(f_cfg), 32'd0);
    chk("rst_cfg_ins", cfg_ins, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_tmo), 32'd0);
    align();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_rdy", 32'(rx_rdy), 32'd1);
    align();

    // basic words with latency and busy release
    cfg_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].bytes, 1'b0);
      @(negedge clk);
      chk("lat_early", 32'(f_cfg), 32'd0);
      @(negedge clk);
      chk("lat_fire", 32'(f_cfg), 32'd1);
      chk("vec_word", cfg_ins, tbl[i].exp);
      repeat (3) @(negedge clk);
      chk("vec_busy_done", 32'(busy), 32'd0);
      align();
    end

    // spacing with N_GAP=2
    cfg_en = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'h01020304 + 32'(i), 1'b0);
    cfg_en = 1'b1;
    pulses.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_cfg) pulses.push_back(i);
    end
    chk("gap2_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("gap2_diff0", 32'(pulses[1] - pulses[0]), 32'd3);
      chk("gap2_diff1", 32'(pulses[2] - pulses[1]), 32'd3);
    end
    align();

    // back-to-back with N_GAP=0
    cfg_en0 = 1'b0;
    for (int k = 0; k < 12; k++) send_byte(8'(8'h30 + k), 1'b1);
    cfg_en0 = 1'b1;
    pulses.delete();
    words0.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (f_cfg0) begin
        pulses.push_back(i);
        words0.push_back(cfg_ins0);
      end
    end
    chk("gap0_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("gap0_diff0", 32'(pulses[1] - pulses[0]), 32'd1);
      chk("gap0_diff1", 32'(pulses[2] - pulses[1]), 32'd1);
      chk("gap0_w0", words0[0], 32'h30313233);
      chk("gap0_w1", words0[1], 32'h34353637);
      chk("gap0_w2", words0[2], 32'h38393A3B);
    end
    align();
    cfg_en0 = 1'b0;

    // backpressure: 20 bytes into a 4-deep FIFO
    cfg_en = 1'b0;
    acc = 0;
    rx_dat = 8'd3;
    rx_vld = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (rx_rdy) begin
        @(posedge clk);
        #1;
        acc++;
        rx_dat = 8'(acc * 7 + 3);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd16);
    @(negedge clk);
    chk("bp_rdy_low", 32'(rx_rdy), 32'd0);
    align();
    cfg_en = 1'b1;
    for (int c = 0; c < 100 && acc < 20; c++) begin
      @(negedge clk);
      if (rx_rdy) begin
        @(posedge clk);
        #1;
        acc++;
        rx_dat = 8'(acc * 7 + 3);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    rx_vld = 1'b0;
    chk("bp_all_accepted", 32'(acc), 32'd20);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_rdy_high", 32'(rx_rdy), 32'd1);
    align();

    // partial-word timeout
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    errs = 0;
    for (int i = 0; i < TMO + 10; i++) begin
      @(negedge clk);
      if (err_tmo) errs++;
    end
    chk("tmo_pulses", 32'(errs), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    align();
    send_word(32'hAABBCCDD, 1'b0);
    wait_pulse(n, 10);
    chk("tmo_next_word", cfg_ins, 32'hAABBCCDD);
    repeat (4) @(negedge clk);
    align();

    // reset during FIRE
    cfg_en = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0);
    cfg_en = 1'b1;
    wait_pulse(n, 10);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_f_cfg", 32'(f_cfg), 32'd0);
    chk("mid_rst_cfg_ins", cfg_ins, 32'd0);
    chk("mid_rst_err", 32'(err_tmo), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_rdy", 32'(rx_rdy), 32'd0);
    align();
    rst = 1'b0;
    pc = 0;
    repeat (20) begin
      @(negedge clk);
      if (f_cfg) pc++;
    end
    chk("mid_rst_no_pulse", 32'(pc), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    align();

    // enable dropped during FIRE
    cfg_en = 1'b0;
    send_word(32'h0BADF00D, 1'b0);
    send_word(32'h600DCAFE, 1'b0);
    cfg_en = 1'b1;
    wait_pulse(n, 10);
    chk("drop_fire_word", cfg_ins, 32'h0BADF00D);
    #1;
    cfg_en = 1'b0;
    pc = 0;
    repeat (10) begin
      @(negedge clk);
      if (f_cfg) pc++;
    end
    chk("drop_no_pop", 32'(pc), 32'd0);
    chk("drop_busy", 32'(busy), 32'd1);
    align();
    cfg_en = 1'b1;
    wait_pulse(n, 10);
    chk("drop_resume_word", cfg_ins, 32'h600DCAFE);
    repeat (5) @(negedge clk);
    align();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rx_vld = ($urandom % 10) < 7;
      rx_dat = 8'($urandom);
      cfg_en = ($urandom % 10) < 8;
      align();
    end
    rx_vld = 1'b0;
    cfg_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    repeat (TMO + 10) @(negedge clk);
    chk("rand_final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rtmq_cfg_loader.md
# rtmq_cfg_loader

Host-side source for the RTMQ core's configuration-override port. It accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into `W_REG`-bit instructions. It buffers the instructions in a small FIFO and injects each one into the core as a single-cycle `f_cfg` pulse with `cfg_ins`, enforcing a programmable minimum spacing between injections. It sits between the host link (UART/SPI deserializer) and the core's `f_cfg`/`cfg_ins` inputs.

## Interface
Parameters:
- `W_REG`, 32: instruction width; must be a multiple of 8.
- `FIFO_DEPTH`, 4: number of assembled instructions buffered; power of two, ≥ 2.
- `N_GAP`, 2: minimum idle cycles between consecutive `f_cfg` pulses; 0 allows back-to-back pulses.
- `T_TMO`, 1000: idle cycles after which a partially assembled word is discarded.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `rx_dat` in 8: incoming byte.
- `rx_vld` in 1: byte valid.
- `rx_rdy` out 1: loader can accept a byte.
- `cfg_en` in 1: injection enable.
- `f_cfg` out 1: configuration-override strobe to the core.
- `cfg_ins` out `W_REG`: instruction to the core. Valid only while `f_cfg` is high.
- `err_tmo` out 1: one-cycle pulse when a partial word is discarded.
- `busy` out 1: high while there is a partial word, the FIFO is non-empty, or `f_cfg` is high.

## Operation
Byte handshake:
- A byte is accepted on any rising edge where `rx_vld & rx_rdy` is high.
- `rx_rdy = ~rst & (fifo_cnt < FIFO_DEPTH)`. It depends only on FIFO occupancy, so no byte is ever dropped.

Word assembly:
- Shift register `asm` and byte counter `bcnt`, range 0 to `W_REG/8 - 1`.
- Each accepted byte does `asm <= {asm[W_REG-9:0], rx_dat}` and increments `bcnt`.
- When the final byte of a word is accepted, the word `{asm[W_REG-9:0], rx_dat}` is pushed to the FIFO and `bcnt` wraps to 0.

Timeout:
- Idle counter resets on every accepted byte and counts while `bcnt != 0`.
- When it reaches `T_TMO`: clear `bcnt` and the counter, and pulse `err_tmo` for one cycle.
- The FIFO is unaffected.

Injection FSM, states IDLE, FIRE, GAP:
- IDLE → FIRE when `cfg_en & fifo_nonempty`. The FIFO head is popped on that edge into the `cfg_ins` register, and `f_cfg` is registered high.
- FIRE lasts exactly one cycle. It goes to GAP with `gap_cnt <= N_GAP`, or straight to IDLE when `N_GAP == 0`.
- GAP decrements `gap_cnt` each cycle and returns to IDLE on the cycle it reads 1.
- With `N_GAP == 0`, FIRE may go directly to FIRE again if the IDLE condition holds.
- Dropping `cfg_en` never truncates a pulse already in FIRE. It only blocks the next pop.

Outputs:
- `cfg_ins` is forced to 0 whenever `f_cfg` is low.

Boundary conditions:
- **Push and pop in the same cycle:** allowed. Occupancy stays the same.
- **FIFO empty:** there is no bypass. A freshly pushed word is poppable from the next cycle.
- **FIFO full:** `rx_rdy` is low, so no push occurs.
- **Reset at any point:** next cycle `bcnt=0`, `fifo_cnt=0`, state IDLE, `f_cfg=0`, `cfg_ins=0`, `err_tmo=0`, `busy=0`. `rx_rdy` is 0 during reset.

## Timing
- Reset values: all outputs 0. `rx_rdy` becomes 1 in the first cycle after `rst` deasserts.
- Latency: the final byte is accepted at edge e0, the FIFO push completes at e0. The pop/FIRE decision is made at edge e0+1, so `f_cfg` is high in the cycle after e0+1.
- Throughput: one injection every `N_GAP+1` cycles. Byte intake is limited to one byte per cycle.
- `f_cfg` and `cfg_ins` are driven directly from registers, with no combinational path from any input.

## Structure
- `W_REG` comes from the shared `RTMQ_Header.v` constants. `N_GAP` and `T_TMO` defaults also belong there as `N_CFG_GAP` and `T_CFG_TMO`.
- One sub-module, `rtmq_sync_fifo`: parameterised width and depth, with `push`, `pop`, `dout`, `cnt`, and synchronous active-high reset, reusable elsewhere.
- Assembler, timeout and injection FSM live in the top level.

## Test plan
- **Basic word:** after reset send bytes 0x12, 0x34, 0x56, 0x78 one per cycle, `cfg_en=1`, `N_GAP=2` → a single `f_cfg` pulse with `cfg_ins=0x12345678`, two cycles after the fourth byte's edge. `busy` returns to 0 after the GAP state.
- **Spacing:** preload 3 words with `cfg_en=0`, then raise `cfg_en` → three pulses exactly 3 cycles apart. With `N_GAP=0`, three consecutive pulses.
- **Backpressure:** `cfg_en=0`, stream 20 bytes → `rx_rdy` falls after the 16th byte (FIFO full at depth 4). Enabling injection drains the words in order and `rx_rdy` rises again. No byte is lost.
- **Timeout:** send 2 bytes, then idle `T_TMO` cycles → `err_tmo` pulses once. The next 4 bytes 0xAA, 0xBB, 0xCC, 0xDD yield `cfg_ins=0xAABBCCDD`.
- **Reset mid-stream:** 3 words queued, pulse `rst` during FIRE → all outputs 0 next cycle, and no further `f_cfg` occurs without new input.
- **Enable drop:** `cfg_en` deasserted in the same cycle as FIRE → the current pulse completes and no further pops occur until re-enabled.
